func_period_acc: RTL and testbench
==================================

Name: func_period_acc

Overview:
Streaming special-node hard-decision unit for the polar SC decoder; the parametrised successor of the fixed 16-LLR Type-I decider.
- Accepts a node's LLRs over 1..MAX_BEATS beats of BEAT_LLRS lanes.
- Accumulates per-class sums for a selectable period P (1 = Repetition, 2 = Type-I, 4 = period-4 node).
- Emits one hard-decision pattern word per node through a valid/ready handshake.
- Sits between the LLR process unit and the partial-sum / bit-memory writer.

Parameters:
LLR_W, 8, signed two's-complement LLR width (matches internal LLR length in defines.v)
BEAT_LLRS, 16, LLRs per input beat; power of two, >= 4
MAX_BEATS, 8, maximum beats per node
ACC_W, LLR_W+$clog2(BEAT_LLRS*MAX_BEATS), accumulator width (derived, not overridable)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
cfg_mode  input  2  0=P1 Rep, 1=P2 Type-I, 2=P4, 3=reserved (treated as P2); sampled on the first beat only
in_valid  input  1  beat valid
in_ready  output  1  beat accepted when in_valid&&in_ready
in_llr  input  BEAT_LLRS*LLR_W  lane 0 in the MSBs, lane i at [(BEAT_LLRS-i)*LLR_W-1 -: LLR_W]
in_last  input  1  final beat of node
out_valid  output  1  pattern valid
out_ready  input  1  downstream accept
out_bits  output  BEAT_LLRS  hard-decision pattern, lane i at bit BEAT_LLRS-1-i
out_beats  output  $clog2(MAX_BEATS+1)  beats consumed by this node
out_err  output  1  node force-terminated at MAX_BEATS without in_last

Behaviour:
- Reset (async, immediate): state=ACC, all accumulators=0, beat count=0, out_valid=0, out_bits=0, out_beats=0, out_err=0, in_ready=1. Reset mid-node discards the partial node; no output is produced for it.
- States:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1, outputs stable.
- ACC, per accepted beat:
  - Each lane is sign-extended to ACC_W.
  - Lane i is added into class acc[i mod P].
  - On the first beat (count==0), accumulators load the beat sums instead of adding, and cfg_mode is latched.
  - Beat count increments by 1.
- ACC -> HOLD when the accepted beat has in_last=1, or when count reaches MAX_BEATS.
  - In the second case out_err=1, even if in_last=0 on that beat.
  - If in_last=1 on beat MAX_BEATS, out_err=0.
- Decision:
  - bit for class c = sign bit of acc[c]; a zero sum gives 0.
  - out_bits lane i = bit[i mod P], i.e. {BEAT_LLRS/P{b[0..P-1]}}.
  - P=1: all lanes equal.
  - P=2: b0 on even lanes, b1 on odd lanes.
  - Decision is registered on HOLD entry.
- Latency: out_valid rises the cycle after the last beat is accepted. Single-beat node: 1 cycle from accept to out_valid.
- HOLD -> ACC on out_valid&&out_ready.
  - Accumulators and count clear on this transition.
  - in_ready returns to 1 the next cycle; there is no same-cycle overlap.
  - Throughput is one node per beats+1 cycles minimum.
- Arithmetic: ACC_W guarantees no overflow for BEAT_LLRS*MAX_BEATS extreme values, including all lanes = -2^(LLR_W-1). No saturation logic.
- cfg_mode changes mid-node are ignored until the next first beat.
- in_valid while in HOLD is not consumed; the source holds the beat.

Decomposition:
- defines.v gets: PERIOD_MODE encodings (MODE_REP, MODE_T1, MODE_P4), and the LLR_W/BEAT_LLRS defaults tied to existing LLR_INTERNAL_LEN / PROCESS_UNIT_LLR_NUM macros.
- One combinational sub-module, llr_class_sum:
  - inputs: one beat and mode.
  - outputs: four ACC_W class sums; unused classes are 0 for P<4.
  - P=1: all lanes go to class 0. P=2: lanes go to class 0/1.
- The top level holds the FSM, accumulators, counter and output register.

Test Plan:
- 1 beat, P=2, lanes alternate +5/-3, in_last=1 -> out_valid next cycle, out_bits=16'b0101_0101_0101_0101, out_beats=1, out_err=0.
- 2 beats, P=1. Beat0 all +2; beat1 lane0=-100, rest 0 (sum -68) -> out_bits=16'hFFFF. Repeat with beat1 lane0=-32 (sum 0) -> out_bits=0.
- P=4, 8 beats, every lane -128 (LLR_W=8), last on beat 8:
  - -> out_bits=16'hFFFF, out_beats=8, out_err=0.
  - No wrap: class sum = -4096 fits ACC_W=15.
- 8 beats, in_last never asserted -> HOLD after 8th accept, out_err=1, in_ready=0 until out_ready.
- out_ready held low 5 cycles in HOLD -> out_valid, out_bits and out_beats stable; in_ready=0; pending in_valid beat not consumed.
- Assert rst mid-node after beat 2 of 4 -> outputs 0 immediately. A fresh 1-beat node afterwards decides from its own LLRs only. cfg_mode toggled mid-node has no effect.

Source files
------------

// File: rtl/func_period_acc_pkg.sv
// rtl/func_period_acc_pkg.sv - period mode encodings, FSM states and class-index helper
package func_period_acc_pkg;

  typedef enum logic [1:0] {
    MODE_REP  = 2'd0,
    MODE_T1   = 2'd1,
    MODE_P4   = 2'd2,
    MODE_RSVD = 2'd3
  } period_mode_e;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Lane index ANDed with this mask gives its class; reserved mode behaves as P=2.
  function automatic logic [1:0] class_mask(input logic [1:0] mode);
    case (mode)
      MODE_REP: class_mask = 2'd0;
      MODE_P4:  class_mask = 2'd3;
      default:  class_mask = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/llr_class_sum.sv
// rtl/llr_class_sum.sv - combinational per-class sum of one beat of LLRs
module llr_class_sum
  import func_period_acc_pkg::*;
#(
  parameter int LLR_W     = 8,
  parameter int BEAT_LLRS = 16,
  parameter int ACC_W     = 15
) (
  input  logic [BEAT_LLRS*LLR_W-1:0] beat,
  input  logic [1:0]                 mode,
  output logic [ACC_W-1:0]           sum0,
  output logic [ACC_W-1:0]           sum1,
  output logic [ACC_W-1:0]           sum2,
  output logic [ACC_W-1:0]           sum3
);

  logic signed [ACC_W-1:0] s [4];
  logic signed [LLR_W-1:0] lane;
  logic signed [ACC_W-1:0] ext;
  logic [1:0]              mask;
  logic [1:0]              cls;

  always_comb begin
    for (int c = 0; c < 4; c++) s[c] = '0;
    lane = '0;
    ext  = '0;
    cls  = '0;
    mask = class_mask(mode);
    for (int i = 0; i < BEAT_LLRS; i++) begin
      lane  = beat[(BEAT_LLRS-i)*LLR_W-1 -: LLR_W];
      ext   = {{(ACC_W-LLR_W){lane[LLR_W-1]}}, lane};
      cls   = 2'(i) & mask;
      s[cls] = s[cls] + ext;
    end
  end

  assign sum0 = s[0];
  assign sum1 = s[1];
  assign sum2 = s[2];
  assign sum3 = s[3];

endmodule

// File: rtl/func_period_acc.sv
// rtl/func_period_acc.sv - streaming periodic-node hard-decision unit with valid/ready output
module func_period_acc
  import func_period_acc_pkg::*;
#(
  parameter int LLR_W     = 8,
  parameter int BEAT_LLRS = 16,
  parameter int MAX_BEATS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     cfg_mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BEAT_LLRS*LLR_W-1:0]     in_llr,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BEAT_LLRS-1:0]           out_bits,
  output logic [$clog2(MAX_BEATS+1)-1:0] out_beats,
  output logic                           out_err
);

  localparam int ACC_W = LLR_W + $clog2(BEAT_LLRS * MAX_BEATS);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q [4];
  logic signed [ACC_W-1:0] acc_d [4];
  logic [ACC_W-1:0]        sum [4];
  logic [CNT_W-1:0]        cnt_q;
  logic [1:0]              mode_q;
  logic [1:0]              mode_eff;
  logic [1:0]              mask;
  logic                    first;
  logic                    accept;
  logic                    last_beat;
  logic [BEAT_LLRS-1:0]    dec_bits;
  logic [BEAT_LLRS-1:0]    out_bits_q;
  logic [CNT_W-1:0]        out_beats_q;
  logic                    out_err_q;

  llr_class_sum #(
    .LLR_W     (LLR_W),
    .BEAT_LLRS (BEAT_LLRS),
    .ACC_W     (ACC_W)
  ) u_class_sum (
    .beat (in_llr),
    .mode (mode_eff),
    .sum0 (sum[0]),
    .sum1 (sum[1]),
    .sum2 (sum[2]),
    .sum3 (sum[3])
  );

  // The first beat of a node uses the live cfg_mode; later beats use the latched copy.
  always_comb begin
    first     = (cnt_q == '0);
    mode_eff  = first ? cfg_mode : mode_q;
    mask      = class_mask(mode_eff);
    accept    = in_valid && in_ready;
    last_beat = accept && (in_last || (cnt_q == CNT_W'(MAX_BEATS - 1)));
    for (int c = 0; c < 4; c++)
      acc_d[c] = first ? signed'(sum[c]) : acc_q[c] + signed'(sum[c]);
    dec_bits = '0;
    for (int i = 0; i < BEAT_LLRS; i++)
      dec_bits[BEAT_LLRS-1-i] = acc_d[2'(i) & mask][ACC_W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_ACC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:  if (last_beat) state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_ACC);
    out_valid = (state_q == ST_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) acc_q[c] <= '0;
      cnt_q       <= '0;
      mode_q      <= MODE_REP;
      out_bits_q  <= '0;
      out_beats_q <= '0;
      out_err_q   <= 1'b0;
    end else if (state_q == ST_ACC) begin
      if (accept) begin
        for (int c = 0; c < 4; c++) acc_q[c] <= acc_d[c];
        cnt_q <= cnt_q + CNT_W'(1);
        if (first) mode_q <= cfg_mode;
        if (last_beat) begin
          out_bits_q  <= dec_bits;
          out_beats_q <= cnt_q + CNT_W'(1);
          out_err_q   <= !in_last;
        end
      end
    end else if (out_ready) begin
      for (int c = 0; c < 4; c++) acc_q[c] <= '0;
      cnt_q <= '0;
    end
  end

  assign out_bits  = out_bits_q;
  assign out_beats = out_beats_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_func_period_acc.sv
// tb/tb_func_period_acc.sv - randomized and directed self-checking bench for func_period_acc
module tb_func_period_acc;

  localparam int LLR_W     = 8;
  localparam int BEAT_LLRS = 16;
  localparam int MAX_BEATS = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   cfg_mode = 2'd0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_llr = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [15:0]  out_bits;
  logic [3:0]   out_beats;
  logic         out_err;

  int checks = 0;
  int errors = 0;
  int beat_llr [MAX_BEATS][BEAT_LLRS];
  logic [15:0] last_obs;

  always #5 clk = ~clk;

  func_period_acc #(
    .LLR_W     (LLR_W),
    .BEAT_LLRS (BEAT_LLRS),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_mode  (cfg_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_llr    (in_llr),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .out_beats (out_beats),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int period_of(input int mode);
    if (mode == 0) return 1;
    if (mode == 2) return 4;
    return 2;
  endfunction

  // Reference: plain integer class sums over the whole node, sign of each sum per lane.
  function automatic logic [15:0] model_bits(input int mode, input int nb);
    int p;
    int s [4];
    logic [15:0] r;
    p = period_of(mode);
    for (int c = 0; c < 4; c++) s[c] = 0;
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < BEAT_LLRS; i++)
        s[i % p] += beat_llr[b][i];
    r = '0;
    for (int i = 0; i < BEAT_LLRS; i++) r[15-i] = (s[i % p] < 0);
    return r;
  endfunction

  function automatic logic [127:0] pack(input int b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < BEAT_LLRS; i++) r[(16-i)*8-1 -: 8] = 8'(beat_llr[b][i]);
    return r;
  endfunction

  task automatic drive_beat(input int b, input int mode, input bit last, input bit toggle);
    @(negedge clk);
    check("in_ready_acc", in_ready, 1);
    in_valid = 1'b1;
    in_llr   = pack(b);
    in_last  = last;
    cfg_mode = (toggle && b > 0) ? 2'(mode ^ $urandom_range(1, 3)) : 2'(mode);
    @(posedge clk);
  endtask

  task automatic run_node(input int mode, input int nb, input bit last, input int hold,
                          input bit toggle, input bit pend);
    logic [15:0] eb;
    logic        ee;
    eb = model_bits(mode, nb);
    ee = (nb == MAX_BEATS) && !last;
    for (int b = 0; b < nb; b++) drive_beat(b, mode, last && (b == nb - 1), toggle);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("out_valid_rise", out_valid, 1);
    check("out_bits", out_bits, eb);
    check("out_beats", out_beats, 64'(nb));
    check("out_err", out_err, ee);
    check("in_ready_hold", in_ready, 0);
    last_obs = out_bits;
    for (int h = 0; h < hold; h++) begin
      if (pend) begin
        in_valid = 1'b1;
        in_llr   = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_bits", out_bits, eb);
      check("hold_beats", out_beats, 64'(nb));
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_bits", out_bits, 0);
    check("rst_beats", out_beats, 0);
    check("rst_err", out_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // P=2 single beat, +5 even / -3 odd
    for (int i = 0; i < BEAT_LLRS; i++) beat_llr[0][i] = (i % 2 == 0) ? 5 : -3;
    run_node(1, 1, 1'b1, 0, 1'b0, 1'b0);
    check("t1_pattern", last_obs, 16'h5555);

    // P=1 two beats: sum -68, then sum exactly 0
    for (int i = 0; i < BEAT_LLRS; i++) begin
      beat_llr[0][i] = 2;
      beat_llr[1][i] = 0;
    end
    beat_llr[1][0] = -100;
    run_node(0, 2, 1'b1, 0, 1'b0, 1'b0);
    check("rep_neg", last_obs, 16'hFFFF);
    beat_llr[1][0] = -32;
    run_node(0, 2, 1'b1, 0, 1'b0, 1'b0);
    check("rep_zero", last_obs, 16'h0000);

    // P=4, 8 beats of most-negative LLRs, last on beat 8
    for (int b = 0; b < MAX_BEATS; b++)
      for (int i = 0; i < BEAT_LLRS; i++) beat_llr[b][i] = -128;
    run_node(2, 8, 1'b1, 0, 1'b0, 1'b0);
    check("p4_extreme", last_obs, 16'hFFFF);

    // 8 beats, no in_last: forced termination, held 5 cycles with a pending beat
    for (int b = 0; b < MAX_BEATS; b++)
      for (int i = 0; i < BEAT_LLRS; i++) beat_llr[b][i] = int'($urandom_range(0, 255)) - 128;
    run_node(1, 8, 1'b0, 5, 1'b0, 1'b1);

    // Reset mid-node after 2 of 4 beats, then a fresh single-beat node
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < BEAT_LLRS; i++) beat_llr[b][i] = -120;
    drive_beat(0, 0, 1'b0, 1'b0);
    drive_beat(1, 0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_bits", out_bits, 0);
    check("midrst_beats", out_beats, 0);
    check("midrst_err", out_err, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < BEAT_LLRS; i++) beat_llr[0][i] = 7;
    run_node(0, 1, 1'b1, 0, 1'b0, 1'b0);
    check("post_rst_fresh", last_obs, 16'h0000);

    // Multi-beat node with cfg_mode toggled after the first beat
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < BEAT_LLRS; i++) beat_llr[b][i] = (i % 4 == 1) ? -9 : 4;
    run_node(2, 3, 1'b1, 1, 1'b1, 1'b0);
    check("toggle_p4", last_obs, 16'h4444);

    // Randomized nodes
    for (int n = 0; n < 30; n++) begin
      int  mode;
      int  nb;
      bit  last;
      mode = int'($urandom_range(0, 3));
      nb   = int'($urandom_range(1, MAX_BEATS));
      last = (nb < MAX_BEATS) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int b = 0; b < nb; b++)
        for (int i = 0; i < BEAT_LLRS; i++) beat_llr[b][i] = int'($urandom_range(0, 255)) - 128;
      run_node(mode, nb, last, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
